axis_video_pattern_gen: RTL and testbench
=========================================

// Module: axis_video_pattern_gen
// PURPOSE
//  Synthesizable AXI4-Stream video source with parametrised frame size, data width and burst/gap
//  timing. Replaces hand-written bench stimulus; feeds the gamma/debug monitor and MemBlock.
//  Emits tuser on the first pixel of each frame, tlast on the last pixel of each line, and
//  honours downstream tready backpressure.
// PARAMETERS
//  DATA_W     24        tdata width (8..32)
//  H_ACTIVE   640       pixels per line (>=2)
//  V_ACTIVE   480       lines per frame (>=1)
//  BURST_LEN  4         accepted beats per burst inside a line (>=1)
//  PIX_GAP    3         idle cycles between bursts in a line (0 = none)
//  LINE_GAP   7         idle cycles after each tlast beat
//  FRAME_GAP  16        extra idle cycles after the last line of a frame
//  CONST_PIX  24'h808080  pixel value for mode 2 (zero-extended/truncated to DATA_W)
// PORTS
//  clk                  in   1       clock
//  rstn                 in   1       reset, asynchronous, active-high
//  enable               in   1       run; sampled at frame boundary
//  mode                 in   2       0 frame pixel index, 1 x coord, 2 CONST_PIX, 3 y coord
//  m_axis_video_tready  in   1       downstream ready
//  m_axis_video_tdata   out  DATA_W  pixel
//  m_axis_video_tvalid  out  1       beat valid
//  m_axis_video_tuser   out  1       start of frame (x=0,y=0 only)
//  m_axis_video_tlast   out  1       end of line (x=H_ACTIVE-1)
//  busy                 out  1       frame in progress
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, x=y=burst=gap counters 0. All outputs registered.
//  FSM: IDLE -> ACTIVE when enable=1 (mode latched into mode_q, busy=1). 1 cycle latency:
//    tvalid rises the cycle after enable is seen.
//  ACTIVE: tvalid=1; beat accepted when tvalid&&tready; x++, burst++ on accept.
//    tdata/tuser/tlast/tvalid held stable while tvalid&&!tready (AXI rule, no retraction).
//  Burst end (burst==BURST_LEN-1 accepted, not line end, PIX_GAP>0) -> PGAP for PIX_GAP cycles,
//    tvalid=0, then ACTIVE. PIX_GAP=0: stay ACTIVE, no bubble.
//  Line end (x==H_ACTIVE-1 accepted): x=0, burst=0, y++; -> LGAP for LINE_GAP cycles
//    (0 = direct), then ACTIVE. Line end takes priority over burst end in the same beat.
//  Frame end (line end with y==V_ACTIVE-1): y=0; -> FGAP for LINE_GAP+FRAME_GAP cycles, then
//    ACTIVE if enable=1 (new mode latched) else IDLE (busy=0).
//  enable dropped mid-frame: current frame completes; never a truncated frame.
//  mode change mid-frame: ignored until next frame start.
//  tdata: mode0 = y*H_ACTIVE+x mod 2^DATA_W; mode1 = x; mode3 = y (zero-extended);
//    mode2 = CONST_PIX[DATA_W-1:0].
//  Counters sized $clog2 of their max; wrap exactly at H_ACTIVE/V_ACTIVE, no overflow path.
//  Async reset mid-frame: outputs drop to 0 immediately; after release restart at x=y=0 with tuser.
// CONFIGURATION
//  PATGEN_STATS_EN defined: adds outputs frame_cnt[15:0] (++ on each frame-end beat, wraps),
//    line_cnt[15:0] (++ on each tlast beat, cleared at frame start), stall_cnt[31:0]
//    (++ every cycle tvalid&&!tready, saturates at 32'hFFFFFFFF). All reset to 0.
//  Undefined: those ports and registers do not exist; core behaviour identical.
// TESTING  (H_ACTIVE=16, V_ACTIVE=4, BURST_LEN=4, PIX_GAP=3, LINE_GAP=7, FRAME_GAP=16)
//  1 tready=1, enable pulse, mode0 -> 64 beats tdata 0..63, tuser only on beat 0, tlast on
//    x=15, 3-cycle tvalid gaps after beats 3,7,11 of each line, 7-cycle gap after tlast.
//  2 Random tready (50%) -> tdata/tuser/tlast stable during every stall, same 64-value sequence,
//    stall_cnt equals counted stall cycles (STATS_EN).
//  3 enable=1 held, mode switched 0->2 mid-frame -> frame 1 finishes mode0, frame 2 all
//    DATA_W'h808080; 23-cycle gap between frames; frame_cnt=2.
//  4 enable dropped at beat 20 -> frame runs to beat 63, then IDLE, busy=0, tvalid stays 0.
//  5 rstn asserted at beat 30 -> tvalid=0 same cycle; after release+enable first beat tdata=0,
//    tuser=1; stats counters 0.
//  6 PIX_GAP=0, LINE_GAP=0, mode1 -> continuous tvalid within a frame, tdata cycles 0..15 per
//    line, 16-cycle bubble only at frame end.

Source files
------------

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream video test-pattern source with burst, line and frame gaps.
// Optional statistics outputs when PATGEN_STATS_EN is defined.
module axis_video_pattern_gen #(
  parameter int          DATA_W    = 24,
  parameter int          H_ACTIVE  = 640,
  parameter int          V_ACTIVE  = 480,
  parameter int          BURST_LEN = 4,
  parameter int          PIX_GAP   = 3,
  parameter int          LINE_GAP  = 7,
  parameter int          FRAME_GAP = 16,
  parameter logic [31:0] CONST_PIX = 32'h0080_8080
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic              m_axis_video_tready,
  output logic [DATA_W-1:0] m_axis_video_tdata,
  output logic              m_axis_video_tvalid,
  output logic              m_axis_video_tuser,
  output logic              m_axis_video_tlast,
`ifdef PATGEN_STATS_EN
  output logic [15:0]       frame_cnt,
  output logic [15:0]       line_cnt,
  output logic [31:0]       stall_cnt,
`endif
  output logic              busy
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int FG_LEN = LINE_GAP + FRAME_GAP;
  localparam int G_MAX = (PIX_GAP > FG_LEN) ? PIX_GAP : FG_LEN;
  localparam int GW = (G_MAX > 1) ? $clog2(G_MAX) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BURST_LEN - 1);
  localparam logic [GW-1:0] PG_LOAD = GW'((PIX_GAP > 0) ? PIX_GAP - 1 : 0);
  localparam logic [GW-1:0] LG_LOAD = GW'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);
  localparam logic [GW-1:0] FG_LOAD = GW'((FG_LEN > 0) ? FG_LEN - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    ACTIVE,
    PGAP,
    LGAP,
    FGAP
  } state_t;

  state_t      state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [BW-1:0] burst;
  logic [GW-1:0] gap;
  logic [1:0]    mode_q;

  logic          accept;
  logic [XW-1:0] ld_x;
  logic [YW-1:0] ld_y;
  logic [1:0]    ld_m;
  logic [DATA_W-1:0] ld_pix;
  logic          ld_user;
  logic          ld_last;

  function automatic logic [DATA_W-1:0] pix(
    input logic [1:0]    m,
    input logic [XW-1:0] px,
    input logic [YW-1:0] py
  );
    logic [63:0] lin;
    lin = 64'(py) * 64'(H_ACTIVE) + 64'(px);
    unique case (m)
      2'd0:    pix = DATA_W'(lin);
      2'd1:    pix = DATA_W'(px);
      2'd2:    pix = CONST_PIX[DATA_W-1:0];
      default: pix = DATA_W'(py);
    endcase
  endfunction

  assign accept = m_axis_video_tvalid && m_axis_video_tready;

  // Coordinates of the beat that would be presented next if a load happens now
  always_comb begin
    ld_m = mode_q;
    ld_x = x;
    ld_y = y;
    if (state == IDLE || state == FGAP ||
        (accept && x == X_LAST && y == Y_LAST)) begin
      ld_m = mode;
      ld_x = '0;
      ld_y = '0;
    end else if (accept && x == X_LAST) begin
      ld_x = '0;
      ld_y = y + YW'(1);
    end else if (accept) begin
      ld_x = x + XW'(1);
    end
    ld_pix  = pix(ld_m, ld_x, ld_y);
    ld_user = (ld_x == '0) && (ld_y == '0);
    ld_last = (ld_x == X_LAST);
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state               <= IDLE;
      x                   <= '0;
      y                   <= '0;
      burst               <= '0;
      gap                 <= '0;
      mode_q              <= '0;
      busy                <= 1'b0;
      m_axis_video_tdata  <= '0;
      m_axis_video_tvalid <= 1'b0;
      m_axis_video_tuser  <= 1'b0;
      m_axis_video_tlast  <= 1'b0;
`ifdef PATGEN_STATS_EN
      frame_cnt           <= '0;
      line_cnt            <= '0;
      stall_cnt           <= '0;
`endif
    end else begin
`ifdef PATGEN_STATS_EN
      if (m_axis_video_tvalid && !m_axis_video_tready &&
          stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
`endif
      unique case (state)
        IDLE: begin
          if (enable) begin
            state               <= ACTIVE;
            mode_q              <= mode;
            busy                <= 1'b1;
            m_axis_video_tvalid <= 1'b1;
            m_axis_video_tdata  <= ld_pix;
            m_axis_video_tuser  <= ld_user;
            m_axis_video_tlast  <= ld_last;
`ifdef PATGEN_STATS_EN
            line_cnt            <= '0;
`endif
          end
        end
        ACTIVE: begin
          if (m_axis_video_tready) begin
            if (x == X_LAST) begin
              x     <= '0;
              burst <= '0;
`ifdef PATGEN_STATS_EN
              line_cnt <= line_cnt + 16'd1;
`endif
              if (y == Y_LAST) begin
                y <= '0;
`ifdef PATGEN_STATS_EN
                frame_cnt <= frame_cnt + 16'd1;
`endif
                if (FG_LEN > 0) begin
                  state               <= FGAP;
                  gap                 <= FG_LOAD;
                  m_axis_video_tvalid <= 1'b0;
                  m_axis_video_tuser  <= 1'b0;
                  m_axis_video_tlast  <= 1'b0;
                end else if (enable) begin
                  mode_q              <= mode;
                  m_axis_video_tdata  <= ld_pix;
                  m_axis_video_tuser  <= ld_user;
                  m_axis_video_tlast  <= ld_last;
`ifdef PATGEN_STATS_EN
                  line_cnt            <= '0;
`endif
                end else begin
                  state               <= IDLE;
                  busy                <= 1'b0;
                  m_axis_video_tvalid <= 1'b0;
                  m_axis_video_tuser  <= 1'b0;
                  m_axis_video_tlast  <= 1'b0;
                end
              end else begin
                y <= y + YW'(1);
                if (LINE_GAP > 0) begin
                  state               <= LGAP;
                  gap                 <= LG_LOAD;
                  m_axis_video_tvalid <= 1'b0;
                  m_axis_video_tuser  <= 1'b0;
                  m_axis_video_tlast  <= 1'b0;
                end else begin
                  m_axis_video_tdata  <= ld_pix;
                  m_axis_video_tuser  <= ld_user;
                  m_axis_video_tlast  <= ld_last;
                end
              end
            end else begin
              x <= x + XW'(1);
              if (burst == B_LAST) begin
                burst <= '0;
                if (PIX_GAP > 0) begin
                  state               <= PGAP;
                  gap                 <= PG_LOAD;
                  m_axis_video_tvalid <= 1'b0;
                  m_axis_video_tuser  <= 1'b0;
                  m_axis_video_tlast  <= 1'b0;
                end else begin
                  m_axis_video_tdata  <= ld_pix;
                  m_axis_video_tuser  <= ld_user;
                  m_axis_video_tlast  <= ld_last;
                end
              end else begin
                burst               <= burst + BW'(1);
                m_axis_video_tdata  <= ld_pix;
                m_axis_video_tuser  <= ld_user;
                m_axis_video_tlast  <= ld_last;
              end
            end
          end
        end
        PGAP, LGAP: begin
          if (gap == '0) begin
            state               <= ACTIVE;
            m_axis_video_tvalid <= 1'b1;
            m_axis_video_tdata  <= ld_pix;
            m_axis_video_tuser  <= ld_user;
            m_axis_video_tlast  <= ld_last;
          end else begin
            gap <= gap - GW'(1);
          end
        end
        FGAP: begin
          if (gap != '0) begin
            gap <= gap - GW'(1);
          end else if (enable) begin
            state               <= ACTIVE;
            mode_q              <= mode;
            m_axis_video_tvalid <= 1'b1;
            m_axis_video_tdata  <= ld_pix;
            m_axis_video_tuser  <= ld_user;
            m_axis_video_tlast  <= ld_last;
`ifdef PATGEN_STATS_EN
            line_cnt            <= '0;
`endif
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// Bench for axis_video_pattern_gen: frame-level reference model with random backpressure.
// Second instance covers the zero pixel/line gap configuration.
module tb_axis_video_pattern_gen;

  localparam int H  = 16;
  localparam int V  = 4;
  localparam int BL = 4;
  localparam int PG = 3;
  localparam int LG = 7;
  localparam int FG = 16;
  localparam int DW = 24;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic en1 = 1'b0;
  logic en2 = 1'b0;
  logic tready = 1'b0;
  logic [1:0] mode = 2'd0;

  logic [DW-1:0] d1, d2, d;
  logic v1, v2, v, u1, u2, u, l1, l2, l, b1, b2, b;
`ifdef PATGEN_STATS_EN
  logic [15:0] fc1, lc1, fc2, lc2;
  logic [31:0] sc1, sc2;
`endif

  always #5 clk = ~clk;

  axis_video_pattern_gen #(
    .DATA_W(DW), .H_ACTIVE(H), .V_ACTIVE(V), .BURST_LEN(BL),
    .PIX_GAP(PG), .LINE_GAP(LG), .FRAME_GAP(FG),
    .CONST_PIX(32'h0080_8080)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(en1), .mode(mode),
    .m_axis_video_tready(tready),
    .m_axis_video_tdata(d1), .m_axis_video_tvalid(v1),
    .m_axis_video_tuser(u1), .m_axis_video_tlast(l1),
`ifdef PATGEN_STATS_EN
    .frame_cnt(fc1), .line_cnt(lc1), .stall_cnt(sc1),
`endif
    .busy(b1)
  );

  axis_video_pattern_gen #(
    .DATA_W(DW), .H_ACTIVE(H), .V_ACTIVE(V), .BURST_LEN(BL),
    .PIX_GAP(0), .LINE_GAP(0), .FRAME_GAP(FG),
    .CONST_PIX(32'h0080_8080)
  ) dut2 (
    .clk(clk), .rstn(rstn), .enable(en2), .mode(mode),
    .m_axis_video_tready(tready),
    .m_axis_video_tdata(d2), .m_axis_video_tvalid(v2),
    .m_axis_video_tuser(u2), .m_axis_video_tlast(l2),
`ifdef PATGEN_STATS_EN
    .frame_cnt(fc2), .line_cnt(lc2), .stall_cnt(sc2),
`endif
    .busy(b2)
  );

  int sel = 1;
  always_comb begin
    d = d1; v = v1; u = u1; l = l1; b = b1;
    if (sel == 2) begin
      d = d2; v = v2; u = u2; l = l2; b = b2;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic          u;
    logic          l;
    int            gap;
  } beat_t;

  beat_t exp_q[$];
  int idle = 0;
  bit seen = 1'b0;
  bit pstall = 1'b0;
  int stalls = 0;

  function automatic logic [DW-1:0] ref_pix(input int m, input int x,
                                            input int y);
    logic [31:0] c;
    c = 32'h0080_8080;
    case (m)
      0:       return DW'(y * H + x);
      1:       return DW'(x);
      2:       return c[DW-1:0];
      default: return DW'(y);
    endcase
  endfunction

  // One frame in raster order; gap = idle cycles expected before the beat
  task automatic push_frame(input int m, input int pg, input int lg,
                            input bit first);
    beat_t bt;
    int px;
    for (int i = 0; i < H * V; i++) begin
      px = (i + H - 1) % H;
      bt.d = ref_pix(m, i % H, i / H);
      bt.u = (i == 0);
      bt.l = (i % H == H - 1);
      if (i == 0) bt.gap = first ? -1 : lg + FG;
      else if (px == H - 1) bt.gap = lg;
      else if (px % BL == BL - 1 && pg > 0) bt.gap = pg;
      else bt.gap = 0;
      exp_q.push_back(bt);
    end
  endtask

  task automatic consume(input int n, input int pct, input int drop_at,
                         input int mode_at, input int new_mode);
    int got;
    int cyc;
    bit rdy;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (got >= drop_at) begin
        en1 = 1'b0;
        en2 = 1'b0;
      end
      if (got >= mode_at) mode = new_mode[1:0];
      if (v) begin
        if (exp_q.size() == 0) begin
          chk("exp_q_empty", exp_q.size(), 1);
          break;
        end
        if (!seen) begin
          seen = 1'b1;
          if (exp_q[0].gap >= 0) chk("gap", idle, exp_q[0].gap);
        end
        chk("tdata", d, exp_q[0].d);
        chk("tuser", u, exp_q[0].u);
        chk("tlast", l, exp_q[0].l);
        chk("busy", b, 1);
        rdy = ($urandom_range(99) < pct);
        tready = rdy;
        if (rdy) begin
          exp_q.delete(0);
          got++;
          idle = 0;
          seen = 1'b0;
        end else begin
          stalls++;
        end
        pstall = !rdy;
      end else begin
        if (pstall) chk("tvalid_held", v, 1);
        pstall = 1'b0;
        idle++;
        tready = ($urandom_range(99) < pct);
      end
    end
    if (got < n) chk("timeout_beats", got, n);
  endtask

  task automatic watch_idle(input int ncyc);
    int nv;
    nv = 0;
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      if (v) nv++;
    end
    chk("idle_tvalid", nv, 0);
    chk("idle_busy", b, 0);
  endtask

  task automatic new_test(input int s);
    sel = s;
    idle = 0;
    seen = 1'b0;
    pstall = 1'b0;
    exp_q.delete();
  endtask

`ifdef PATGEN_STATS_EN
  logic [31:0] sc_base;
  logic [15:0] fc_base;
`endif

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", v1, 0);
    chk("rst_tuser", u1, 0);
    chk("rst_tlast", l1, 0);
    chk("rst_tdata", d1, 0);
    chk("rst_busy", b1, 0);
`ifdef PATGEN_STATS_EN
    chk("rst_stall", sc1, 0);
    chk("rst_frame", fc1, 0);
    chk("rst_line", lc1, 0);
`endif
    rstn = 1'b0;
    @(posedge clk);
    #1;

    // full readiness, mode 0, single enable pulse
    new_test(1);
    mode = 2'd0;
    tready = 1'b1;
    push_frame(0, PG, LG, 1'b1);
    en1 = 1'b1;
    consume(H * V, 100, 0, 1000, 0);
    watch_idle(40);

    // random backpressure
    new_test(1);
    stalls = 0;
`ifdef PATGEN_STATS_EN
    sc_base = sc1;
`endif
    push_frame(0, PG, LG, 1'b1);
    en1 = 1'b1;
    consume(H * V, 50, 0, 1000, 0);
`ifdef PATGEN_STATS_EN
    chk("stall_cnt", sc1 - sc_base, stalls);
`endif
    watch_idle(40);
`ifdef PATGEN_STATS_EN
    chk("line_cnt", lc1, V);
`endif

    // enable held, mode change mid-frame applies to the next frame
    new_test(1);
`ifdef PATGEN_STATS_EN
    fc_base = fc1;
`endif
    mode = 2'd0;
    push_frame(0, PG, LG, 1'b1);
    push_frame(2, PG, LG, 1'b0);
    en1 = 1'b1;
    consume(2 * H * V, 70, H * V + 6, 20, 2);
    watch_idle(40);
`ifdef PATGEN_STATS_EN
    chk("frame_cnt", fc1 - fc_base, 2);
`endif

    // enable dropped mid-frame: frame completes, then idle
    new_test(1);
    mode = 2'd3;
    push_frame(3, PG, LG, 1'b1);
    en1 = 1'b1;
    consume(H * V, 70, 20, 1000, 3);
    watch_idle(60);

    // async reset mid-frame
    new_test(1);
    mode = 2'd1;
    push_frame(1, PG, LG, 1'b1);
    en1 = 1'b1;
    consume(30, 100, 0, 1000, 1);
    rstn = 1'b1;
    #1;
    chk("arst_tvalid", v1, 0);
    chk("arst_tuser", u1, 0);
    chk("arst_busy", b1, 0);
`ifdef PATGEN_STATS_EN
    chk("arst_stall", sc1, 0);
    chk("arst_frame", fc1, 0);
    chk("arst_line", lc1, 0);
`endif
    tready = 1'b0;
    en1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
    new_test(1);
    mode = 2'd0;
    push_frame(0, PG, LG, 1'b1);
    en1 = 1'b1;
    consume(H * V, 60, 0, 1000, 0);
    watch_idle(40);

    // zero pixel/line gaps: continuous within frame, bubble at frame end
    new_test(2);
    mode = 2'd1;
    push_frame(1, 0, 0, 1'b1);
    push_frame(1, 0, 0, 1'b0);
    en2 = 1'b1;
    consume(2 * H * V, 100, H * V + 6, 1000, 1);
    watch_idle(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
